// File: rtl/fft_seq_ctrl_p_if.sv
// Host/datapath-facing signal bundle of the FFT sequencing controller.
// The controller takes the slave view; the host/bench takes the master view.
interface fft_seq_ctrl_p_if;
  logic       start;
  logic [3:0] seq_mode;
  logic [3:0] log_n;
  logic       stall;
  logic       abort;
  logic       bf_we_req;

  logic [1:0] agu_mode;
  logic       agu_start;
  logic       agu_oe;
  logic       ram_cs_0;
  logic       ram_oe_0;
  logic       ram_cs_1;
  logic       ram_we_1;
  logic       rom_cs;
  logic       rom_re;
  logic       bf_start;
  logic       io_in_en;
  logic       io_out_en;
  logic [3:0] stage;
  logic       phase_term;
  logic       busy;
  logic       tip;
  logic       done;
  logic       aborted;

  modport master (
    output start, seq_mode, log_n, stall, abort, bf_we_req,
    input  agu_mode, agu_start, agu_oe, ram_cs_0, ram_oe_0, ram_cs_1, ram_we_1,
           rom_cs, rom_re, bf_start, io_in_en, io_out_en, stage, phase_term,
           busy, tip, done, aborted
  );

  modport slave (
    input  start, seq_mode, log_n, stall, abort, bf_we_req,
    output agu_mode, agu_start, agu_oe, ram_cs_0, ram_oe_0, ram_cs_1, ram_we_1,
           rom_cs, rom_re, bf_start, io_in_en, io_out_en, stage, phase_term,
           busy, tip, done, aborted
  );
endinterface

// File: rtl/fft_seq_ctrl_p.sv
// FFT sequencing controller: load, twiddle copy, butterfly stages and unload
// phases in fixed order, with run-time point count, IO stall, and abort.
module fft_seq_ctrl_p #(
  parameter int MAX_LOG_N = 10,
  parameter int IO_WORDS  = 2,
  parameter int BF_CYCLES = 8,
  parameter int BF_FILL   = 3,
  parameter int UL_FILL   = 2,
  parameter int CNT_W     = MAX_LOG_N + 4
) (
  input logic              extc_base_clock,
  input logic              extc_reset,
  fft_seq_ctrl_p_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ROMCPY, S_BF_FILL, S_BF_RUN, S_UL_FILL, S_UNLOAD, S_DONE
  } state_t;

  state_t             state_q, state_nxt;
  logic [CNT_W-1:0]   cnt_q;
  logic [3:0]         stage_q;
  logic [3:0]         mode_q;
  logic [3:0]         log_n_q;
  logic               aborted_q;

  logic               cnt_clr, cnt_inc, stage_inc, stage_clr, abort_take;
  logic [CNT_W-1:0]   pts, io_len, stage_len;

  logic [1:0] agu_mode_c;
  logic agu_en_c, ram_rd_c, ram_cs_1_c, ram_we_1_c, rom_c, bf_start_c;
  logic io_in_en_c, io_out_en_c, phase_term_c;

  function automatic logic [3:0] clamp_log_n(input logic [3:0] v);
    if (v < 4'd2) return 4'd2;
    if (v > 4'(MAX_LOG_N)) return 4'(MAX_LOG_N);
    return v;
  endfunction

  // Next enabled phase strictly after 'cur'; DONE when none remain.
  function automatic state_t next_phase(input logic [3:0] mode, input state_t cur);
    logic [3:0] m;
    case (cur)
      S_IDLE:   m = mode;
      S_LOAD:   m = mode & 4'b0111;
      S_ROMCPY: m = mode & 4'b0011;
      S_BF_RUN: m = mode & 4'b0001;
      default:  m = 4'b0000;
    endcase
    if (m[3]) return S_LOAD;
    if (m[2]) return S_ROMCPY;
    if (m[1]) return S_BF_FILL;
    if (m[0]) return S_UL_FILL;
    return S_DONE;
  endfunction

  assign pts       = CNT_W'(1) << log_n_q;
  assign io_len    = pts * CNT_W'(IO_WORDS);
  assign stage_len = (pts >> 1) * CNT_W'(BF_CYCLES);

  always_comb begin
    state_nxt    = state_q;
    cnt_clr      = 1'b0;
    cnt_inc      = 1'b0;
    stage_inc    = 1'b0;
    stage_clr    = 1'b0;
    abort_take   = 1'b0;
    agu_mode_c   = 2'd0;
    agu_en_c     = 1'b0;
    ram_rd_c     = 1'b0;
    ram_cs_1_c   = 1'b0;
    ram_we_1_c   = 1'b0;
    rom_c        = 1'b0;
    bf_start_c   = 1'b0;
    io_in_en_c   = 1'b0;
    io_out_en_c  = 1'b0;
    phase_term_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) state_nxt = next_phase(bus.seq_mode, S_IDLE);
      end
      S_LOAD: begin
        agu_en_c   = 1'b1;
        io_in_en_c = 1'b1;
        ram_cs_1_c = ~bus.stall;
        ram_we_1_c = ~bus.stall;
        if (!bus.stall) begin
          cnt_inc = 1'b1;
          if (cnt_q == io_len - CNT_W'(1)) begin
            phase_term_c = 1'b1;
            state_nxt    = next_phase(mode_q, S_LOAD);
          end
        end
      end
      S_ROMCPY: begin
        agu_mode_c = 2'd1;
        agu_en_c   = 1'b1;
        rom_c      = 1'b1;
        ram_cs_1_c = 1'b1;
        ram_we_1_c = 1'b1;
        cnt_inc    = 1'b1;
        if (cnt_q == pts - CNT_W'(1)) begin
          phase_term_c = 1'b1;
          state_nxt    = next_phase(mode_q, S_ROMCPY);
        end
      end
      S_BF_FILL: begin
        agu_mode_c = 2'd2;
        agu_en_c   = 1'b1;
        ram_rd_c   = 1'b1;
        ram_cs_1_c = 1'b1;
        cnt_inc    = 1'b1;
        if (cnt_q == CNT_W'(BF_FILL - 1)) state_nxt = S_BF_RUN;
      end
      S_BF_RUN: begin
        agu_mode_c = 2'd2;
        agu_en_c   = 1'b1;
        ram_rd_c   = 1'b1;
        ram_cs_1_c = 1'b1;
        ram_we_1_c = bus.bf_we_req;
        bf_start_c = 1'b1;
        cnt_inc    = 1'b1;
        if (cnt_q == stage_len - CNT_W'(1)) begin
          if (stage_q == log_n_q - 4'd1) begin
            phase_term_c = 1'b1;
            stage_clr    = 1'b1;
            state_nxt    = next_phase(mode_q, S_BF_RUN);
          end else begin
            stage_inc = 1'b1;
            cnt_clr   = 1'b1;
          end
        end
      end
      S_UL_FILL: begin
        agu_mode_c = 2'd3;
        agu_en_c   = 1'b1;
        ram_rd_c   = 1'b1;
        cnt_inc    = 1'b1;
        if (cnt_q == CNT_W'(UL_FILL - 1)) state_nxt = S_UNLOAD;
      end
      S_UNLOAD: begin
        agu_mode_c  = 2'd3;
        agu_en_c    = 1'b1;
        ram_rd_c    = 1'b1;
        io_out_en_c = ~bus.stall;
        if (!bus.stall) begin
          cnt_inc = 1'b1;
          if (cnt_q == io_len - CNT_W'(1)) begin
            phase_term_c = 1'b1;
            state_nxt    = S_DONE;
          end
        end
      end
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    // Abort overrides any phase completion decided above.
    if (bus.abort && state_q != S_IDLE) begin
      abort_take = 1'b1;
      state_nxt  = S_IDLE;
      stage_clr  = 1'b1;
    end
    if (state_nxt != state_q) cnt_clr = 1'b1;
  end

  // ---- state register ----
  always_ff @(posedge extc_base_clock) begin
    if (extc_reset) state_q <= S_IDLE;
    else            state_q <= state_nxt;
  end

  // ---- counters, latched run configuration, abort pulse ----
  always_ff @(posedge extc_base_clock) begin
    if (extc_reset) begin
      cnt_q     <= '0;
      stage_q   <= '0;
      mode_q    <= '0;
      log_n_q   <= 4'd2;
      aborted_q <= 1'b0;
    end else begin
      aborted_q <= abort_take;
      if (cnt_clr)      cnt_q <= '0;
      else if (cnt_inc) cnt_q <= cnt_q + CNT_W'(1);
      if (stage_clr)      stage_q <= '0;
      else if (stage_inc) stage_q <= stage_q + 4'd1;
      if (state_q == S_IDLE && bus.start) begin
        mode_q  <= bus.seq_mode;
        log_n_q <= clamp_log_n(bus.log_n);
      end
    end
  end

  assign bus.agu_mode   = agu_mode_c;
  assign bus.agu_start  = agu_en_c;
  assign bus.agu_oe     = agu_en_c;
  assign bus.ram_cs_0   = ram_rd_c;
  assign bus.ram_oe_0   = ram_rd_c;
  assign bus.ram_cs_1   = ram_cs_1_c;
  assign bus.ram_we_1   = ram_we_1_c;
  assign bus.rom_cs     = rom_c;
  assign bus.rom_re     = rom_c;
  assign bus.bf_start   = bf_start_c;
  assign bus.io_in_en   = io_in_en_c;
  assign bus.io_out_en  = io_out_en_c;
  assign bus.stage      = stage_q;
  assign bus.phase_term = phase_term_c;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.tip        = (state_q == S_LOAD) || (state_q == S_UNLOAD);
  assign bus.done       = (state_q == S_DONE);
  assign bus.aborted    = aborted_q;

endmodule

// File: tb/tb_fft_seq_ctrl_p.sv
// Directed bench for fft_seq_ctrl_p; cycle 1 is the first cycle after the
// edge that samples start.
module tb_fft_seq_ctrl_p;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fft_seq_ctrl_p_if bus_if();
  fft_seq_ctrl_p dut (.extc_base_clock(clk), .extc_reset(rst), .bus(bus_if));

  int n_vec = 0;
  int n_err = 0;

  int done_cyc, done_cnt, abort_cyc, we_cnt, pt_cnt, pt_last;
  int bfs_cnt, ioo_cnt, rom_cnt, en_cnt;
  logic timeout;
  logic       we_h    [0:2199];
  logic       en_h    [0:2199];
  logic       busy_h  [0:2199];
  logic [3:0] stage_h [0:2199];
  logic [1:0] mode_h  [0:2199];

  function automatic logic any_en();
    return bus_if.agu_start | bus_if.agu_oe | bus_if.ram_cs_0 | bus_if.ram_oe_0 |
           bus_if.ram_cs_1 | bus_if.ram_we_1 | bus_if.rom_cs | bus_if.rom_re |
           bus_if.bf_start | bus_if.io_in_en | bus_if.io_out_en;
  endfunction

  // Drive one sequence; stalls on cycles st_lo..st_hi, abort on ab_at,
  // a second start with different config on rs_at. Records per-cycle history.
  task automatic run(input logic [3:0] mode, input logic [3:0] ln, input int st_lo,
                     input int st_hi, input int ab_at, input int rs_at,
                     input logic we_req, input int max_cyc);
    logic stop;
    stop = 1'b0;
    done_cyc = -1; done_cnt = 0; abort_cyc = -1; we_cnt = 0; pt_cnt = 0; pt_last = -1;
    bfs_cnt = 0; ioo_cnt = 0; rom_cnt = 0; en_cnt = 0; timeout = 1'b0;
    bus_if.seq_mode = mode; bus_if.log_n = ln; bus_if.start = 1'b1;
    bus_if.bf_we_req = we_req; bus_if.stall = 1'b0; bus_if.abort = 1'b0;
    @(posedge clk); #1;
    for (int c = 1; c <= max_cyc && !stop; c++) begin
      bus_if.stall = (c >= st_lo && c <= st_hi);
      bus_if.abort = (c == ab_at);
      if (c == rs_at) begin
        bus_if.start = 1'b1; bus_if.seq_mode = 4'b1111; bus_if.log_n = 4'd5;
      end else bus_if.start = 1'b0;
      #2;
      we_h[c] = bus_if.ram_we_1; en_h[c] = any_en(); busy_h[c] = bus_if.busy;
      stage_h[c] = bus_if.stage; mode_h[c] = bus_if.agu_mode;
      if (bus_if.ram_we_1) we_cnt++;
      if (bus_if.bf_start) bfs_cnt++;
      if (bus_if.io_out_en) ioo_cnt++;
      if (bus_if.rom_re) rom_cnt++;
      if (any_en()) en_cnt++;
      if (bus_if.phase_term) begin pt_cnt++; pt_last = c; end
      if (bus_if.done) begin done_cnt++; done_cyc = c; stop = 1'b1; end
      if (bus_if.aborted) begin abort_cyc = c; stop = 1'b1; end
      @(posedge clk); #1;
    end
    if (!stop) timeout = 1'b1;
    bus_if.start = 1'b0; bus_if.stall = 1'b0; bus_if.abort = 1'b0;
  endtask

  task automatic test_reset();
    bus_if.start = 1'b0; bus_if.seq_mode = 4'd0; bus_if.log_n = 4'd3;
    bus_if.stall = 1'b0; bus_if.abort = 1'b0; bus_if.bf_we_req = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (bus_if.busy !== 1'b0) begin $display("FAIL rst_busy: got %0b expected 0", bus_if.busy); n_err++; end
    n_vec++; if (any_en() !== 1'b0) begin $display("FAIL rst_enables: got %0b expected 0", any_en()); n_err++; end
    n_vec++; if ({bus_if.done, bus_if.aborted, bus_if.phase_term, bus_if.tip} !== 4'b0)
      begin $display("FAIL rst_pulses: got %b expected 0000", {bus_if.done, bus_if.aborted, bus_if.phase_term, bus_if.tip}); n_err++; end
    n_vec++; if ({bus_if.stage, bus_if.agu_mode} !== 6'd0)
      begin $display("FAIL rst_stage_mode: got %0d expected 0", {bus_if.stage, bus_if.agu_mode}); n_err++; end
    rst = 1'b0;
    bus_if.abort = 1'b1;
    @(posedge clk); #1;
    bus_if.abort = 1'b0;
    #1;
    n_vec++; if ({bus_if.aborted, bus_if.busy} !== 2'b00)
      begin $display("FAIL idle_abort_ignored: got %b expected 00", {bus_if.aborted, bus_if.busy}); n_err++; end
  endtask

  task automatic test_load_only();
    run(4'b1000, 4'd3, 0, -1, -1, -1, 1'b0, 40);
    n_vec++; if (timeout !== 1'b0) begin $display("FAIL load_timeout: got %0b expected 0", timeout); n_err++; end
    n_vec++; if (we_cnt != 16) begin $display("FAIL load_we_cnt: got %0d expected 16", we_cnt); n_err++; end
    n_vec++; if (pt_cnt != 1 || pt_last != 16) begin $display("FAIL load_phase_term: got %0d@%0d expected 1@16", pt_cnt, pt_last); n_err++; end
    n_vec++; if (done_cyc != 17) begin $display("FAIL load_done_cyc: got %0d expected 17", done_cyc); n_err++; end
    n_vec++; if (busy_h[17] !== 1'b1) begin $display("FAIL load_busy_in_done: got %0b expected 1", busy_h[17]); n_err++; end
    #1;
    n_vec++; if (bus_if.busy !== 1'b0 || bus_if.done !== 1'b0)
      begin $display("FAIL load_back_idle: got %b expected 00", {bus_if.busy, bus_if.done}); n_err++; end
  endtask

  task automatic test_stall();
    run(4'b1000, 4'd3, 4, 6, -1, -1, 1'b0, 60);
    n_vec++; if (we_cnt != 16) begin $display("FAIL stall_we_cnt: got %0d expected 16", we_cnt); n_err++; end
    n_vec++; if ({we_h[3], we_h[4], we_h[5], we_h[6], we_h[7]} !== 5'b10001)
      begin $display("FAIL stall_we_pattern: got %b expected 10001", {we_h[3], we_h[4], we_h[5], we_h[6], we_h[7]}); n_err++; end
    n_vec++; if (pt_cnt != 1 || pt_last != 19) begin $display("FAIL stall_phase_term: got %0d@%0d expected 1@19", pt_cnt, pt_last); n_err++; end
    n_vec++; if (done_cyc != 20) begin $display("FAIL stall_done_cyc: got %0d expected 20", done_cyc); n_err++; end
  endtask

  task automatic test_full_run();
    int sc [6] = '{59, 60, 91, 92, 123, 124};
    int se [6] = '{0, 1, 1, 2, 2, 0};
    int mc [7] = '{1, 17, 25, 28, 124, 126, 142};
    int me [7] = '{0, 1, 2, 2, 3, 3, 0};
    run(4'b1111, 4'd3, 0, -1, -1, -1, 1'b1, 300);
    n_vec++; if (done_cyc != 142) begin $display("FAIL full_done_cyc: got %0d expected 142", done_cyc); n_err++; end
    n_vec++; if (we_cnt != 120) begin $display("FAIL full_we_cnt: got %0d expected 120", we_cnt); n_err++; end
    n_vec++; if (bfs_cnt != 96 || rom_cnt != 8 || ioo_cnt != 16)
      begin $display("FAIL full_phase_lengths: got bf=%0d rom=%0d out=%0d expected 96 8 16", bfs_cnt, rom_cnt, ioo_cnt); n_err++; end
    n_vec++; if (pt_cnt != 4 || pt_last != 141) begin $display("FAIL full_phase_term: got %0d@%0d expected 4@141", pt_cnt, pt_last); n_err++; end
    for (int i = 0; i < 6; i++) begin
      n_vec++;
      if (stage_h[sc[i]] !== 4'(se[i])) begin
        $display("FAIL full_stage@%0d: got %0d expected %0d", sc[i], stage_h[sc[i]], se[i]); n_err++;
      end
    end
    for (int i = 0; i < 7; i++) begin
      n_vec++;
      if (mode_h[mc[i]] !== 2'(me[i])) begin
        $display("FAIL full_agu_mode@%0d: got %0d expected %0d", mc[i], mode_h[mc[i]], me[i]); n_err++;
      end
    end
  endtask

  task automatic test_abort();
    run(4'b1111, 4'd3, 0, -1, 37, -1, 1'b0, 300);
    n_vec++; if (abort_cyc != 38) begin $display("FAIL abort_cyc: got %0d expected 38", abort_cyc); n_err++; end
    n_vec++; if (done_cnt != 0) begin $display("FAIL abort_no_done: got %0d expected 0", done_cnt); n_err++; end
    n_vec++; if (en_h[38] !== 1'b0 || busy_h[38] !== 1'b0)
      begin $display("FAIL abort_idle: got %b expected 00", {en_h[38], busy_h[38]}); n_err++; end
    n_vec++; if (we_h[20] !== 1'b1 || we_h[30] !== 1'b0)
      begin $display("FAIL abort_we_gating: got %b expected 10", {we_h[20], we_h[30]}); n_err++; end
    run(4'b1000, 4'd3, 0, -1, -1, -1, 1'b0, 40);
    n_vec++; if (done_cyc != 17 || we_cnt != 16)
      begin $display("FAIL abort_restart: got done@%0d we=%0d expected 17 16", done_cyc, we_cnt); n_err++; end
  endtask

  task automatic test_back_to_back();
    run(4'b1000, 4'd3, 0, -1, -1, 5, 1'b0, 60);
    n_vec++; if (done_cyc != 17) begin $display("FAIL restart_ignored_done: got %0d expected 17", done_cyc); n_err++; end
    n_vec++; if (we_cnt != 16 || rom_cnt != 0)
      begin $display("FAIL restart_ignored_mode: got we=%0d rom=%0d expected 16 0", we_cnt, rom_cnt); n_err++; end
  endtask

  task automatic test_bounds();
    run(4'b0000, 4'd3, 0, -1, -1, -1, 1'b0, 10);
    n_vec++; if (done_cyc != 1 || en_cnt != 0)
      begin $display("FAIL zero_mode: got done@%0d en=%0d expected 1 0", done_cyc, en_cnt); n_err++; end
    run(4'b1000, 4'd15, 0, -1, -1, -1, 1'b0, 2100);
    n_vec++; if (done_cyc != 2049 || we_cnt != 2048)
      begin $display("FAIL clamp_high: got done@%0d we=%0d expected 2049 2048", done_cyc, we_cnt); n_err++; end
    run(4'b1000, 4'd0, 0, -1, -1, -1, 1'b0, 40);
    n_vec++; if (done_cyc != 9 || we_cnt != 8)
      begin $display("FAIL clamp_low: got done@%0d we=%0d expected 9 8", done_cyc, we_cnt); n_err++; end
  endtask

  task automatic test_reset_mid();
    bus_if.seq_mode = 4'b1111; bus_if.log_n = 4'd3; bus_if.start = 1'b1;
    @(posedge clk); #1;
    bus_if.start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    n_vec++; if (bus_if.busy !== 1'b1) begin $display("FAIL midrst_running: got %0b expected 1", bus_if.busy); n_err++; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_vec++; if ({bus_if.busy, bus_if.done, bus_if.aborted, any_en()} !== 4'b0000)
      begin $display("FAIL midrst_idle: got %b expected 0000", {bus_if.busy, bus_if.done, bus_if.aborted, any_en()}); n_err++; end
    @(posedge clk); #1;
    n_vec++; if ({bus_if.done, bus_if.aborted} !== 2'b00)
      begin $display("FAIL midrst_no_pulse: got %b expected 00", {bus_if.done, bus_if.aborted}); n_err++; end
  endtask

  initial begin
    test_reset();
    test_load_only();
    test_stall();
    test_full_run();
    test_abort();
    test_back_to_back();
    test_bounds();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
